// File: rtl/bn_writeback_pkg.sv
// Shared types and constants for the batch-norm writeback path.
package acc_pkg;

  localparam int LANE_W     = 16;
  localparam int LANES      = 4;
  localparam int BN_LAT_DEF = 13;

  typedef enum logic [2:0] {
    COLLECT,
    ISSUE,
    WAIT,
    WR0,
    WR1
  } state_t;

endpackage

// File: rtl/bn_writeback_if.sv
// Conv-result input, BN unit handshake and output SRAM write port.
interface bn_writeback_if #(parameter int ADDR_W = 13);
  import acc_pkg::*;

  logic                      in_valid;
  logic [LANE_W-1:0]         in_data;
  logic                      bn_start;
  logic [LANES*LANE_W-1:0]   bn_input;
  logic [LANES*LANE_W-1:0]   bn_output;
  logic                      sram_we;
  logic [ADDR_W-1:0]         sram_waddr;
  logic [2*LANE_W-1:0]       sram_wdata;

  modport master (
    output in_valid, in_data, bn_output,
    input  bn_start, bn_input, sram_we, sram_waddr, sram_wdata
  );

  modport slave (
    input  in_valid, in_data, bn_output,
    output bn_start, bn_input, sram_we, sram_waddr, sram_wdata
  );

endinterface

// File: rtl/bn_writeback_sync_fifo.sv
// Single-clock FIFO with registered pointers and combinational head read.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;

  // Storage array; no reset needed since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rp];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/bn_writeback.sv
// Packs conv results into 4-lane groups, runs them through the BN unit
// and writes each 64-bit result to the output SRAM as two 32-bit words.
//
//   state   | meaning
//   COLLECT | pop FIFO entries into lanes 0..3
//   ISSUE   | bn_start pulse, bn_input holds the packed group
//   WAIT    | count down the BN latency, capture bn_output at terminal count
//   WR0     | write {lane1,lane0} at addr
//   WR1     | write {lane3,lane2} at addr+1, advance addr by 2
module bn_writeback
  import acc_pkg::*;
#(
  parameter int BN_LAT     = BN_LAT_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              flush,
  bn_writeback_if.slave     bus,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W-1:0] wr_count
);

  state_t                        state;
  logic [1:0]                    nl;
  logic [LANES-1:0][LANE_W-1:0]  lanes, lanes_ins;
  logic [5:0]                    cnt;
  logic [2*LANE_W-1:0]           res_hi;
  logic [ADDR_W-1:0]             addr;
  logic [LANE_W-1:0]             fifo_dout;
  logic                          fifo_full, fifo_empty;
  logic                          flush_go, pop, push;

  // A flush only matters with a partial group; it takes the cycle, so no pop.
  assign flush_go = flush && (state == COLLECT) && (nl != 2'd0);
  assign pop      = (state == COLLECT) && !fifo_empty && !clear && !flush_go;
  assign push     = bus.in_valid && !clear && (!fifo_full || pop);
  assign busy     = (state != COLLECT) || !fifo_empty;

  sync_fifo #(.WIDTH(LANE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .push  (push),
    .pop   (pop),
    .din   (bus.in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Lane vector with the FIFO head dropped into the next free slot.
  always_comb begin
    lanes_ins     = lanes;
    lanes_ins[nl] = fifo_dout;
  end

  // Sequencer with registered BN and SRAM outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= COLLECT;
      nl             <= 2'd0;
      lanes          <= '0;
      cnt            <= '0;
      res_hi         <= '0;
      addr           <= '0;
      wr_count       <= '0;
      overflow       <= 1'b0;
      bus.bn_start   <= 1'b0;
      bus.bn_input   <= '0;
      bus.sram_we    <= 1'b0;
      bus.sram_waddr <= '0;
      bus.sram_wdata <= '0;
    end else if (clear) begin
      state        <= COLLECT;
      nl           <= 2'd0;
      lanes        <= '0;
      cnt          <= '0;
      res_hi       <= '0;
      addr         <= '0;
      wr_count     <= '0;
      overflow     <= 1'b0;
      bus.bn_start <= 1'b0;
      bus.sram_we  <= 1'b0;
    end else begin
      bus.bn_start <= 1'b0;
      bus.sram_we  <= 1'b0;
      if (bus.in_valid && fifo_full && !pop) overflow <= 1'b1;
      case (state)
        COLLECT: begin
          if (flush_go) begin
            bus.bn_input <= lanes;
            lanes        <= '0;
            nl           <= 2'd0;
            bus.bn_start <= 1'b1;
            state        <= ISSUE;
          end else if (pop) begin
            if (nl == 2'd3) begin
              bus.bn_input <= lanes_ins;
              lanes        <= '0;
              nl           <= 2'd0;
              bus.bn_start <= 1'b1;
              state        <= ISSUE;
            end else begin
              lanes <= lanes_ins;
              nl    <= nl + 2'd1;
            end
          end
        end
        ISSUE: begin
          cnt   <= 6'(BN_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 6'd0) begin
            res_hi         <= bus.bn_output[4*LANE_W-1:2*LANE_W];
            bus.sram_we    <= 1'b1;
            bus.sram_waddr <= addr;
            bus.sram_wdata <= bus.bn_output[2*LANE_W-1:0];
            state          <= WR0;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        WR0: begin
          wr_count       <= wr_count + ADDR_W'(1);
          bus.sram_we    <= 1'b1;
          bus.sram_waddr <= addr + ADDR_W'(1);
          bus.sram_wdata <= res_hi;
          state          <= WR1;
        end
        WR1: begin
          wr_count <= wr_count + ADDR_W'(1);
          addr     <= addr + ADDR_W'(2);
          state    <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_bn_writeback.sv
// Randomised and directed bench for bn_writeback against a timing-level model.
module tb_bn_writeback;

  localparam int BN_LAT     = 13;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 5;
  localparam int AMOD       = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              flush = 1'b0;
  logic              busy, overflow;
  logic [ADDR_W-1:0] wr_count;

  bn_writeback_if #(.ADDR_W(ADDR_W)) bif();

  bn_writeback #(.BN_LAT(BN_LAT), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .flush    (flush),
    .bus      (bif.slave),
    .busy     (busy),
    .overflow (overflow),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] bn_f(logic [63:0] x);
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[16*k +: 16] = x[16*k +: 16] + 16'd1;
    return r;
  endfunction

  // BN unit stand-in: result valid only in the cycle BN_LAT after bn_start.
  int          since = -1;
  logic [63:0] lat_in = '0;
  always @(negedge clk) begin
    if (bif.bn_start) begin
      since  = 0;
      lat_in = bif.bn_input;
    end else if (since >= 0 && since < 1000) begin
      since++;
    end
    bif.bn_output = (since == BN_LAT) ? bn_f(lat_in) : {$urandom, $urandom};
  end

  // Reference model: FIFO as a queue, group busy window of ISSUE+BN_LAT+2 cycles.
  logic [15:0] q[$];
  logic [15:0] ml[4];
  int          mnl, hold, maddr, mwrc;
  bit          movf;
  logic [63:0] mgrp;
  logic        exp_we, exp_start, exp_busy, exp_ovf;
  logic [ADDR_W-1:0] exp_waddr, exp_wrc;
  logic [31:0] exp_wdata;
  logic [63:0] exp_input;

  always @(posedge clk or negedge rst_n) begin
    logic [63:0] r;
    if (!rst_n) begin
      q.delete();
      for (int k = 0; k < 4; k++) ml[k] = '0;
      mnl = 0; hold = 0; maddr = 0; mwrc = 0; movf = 0; mgrp = '0;
    end else if (clear) begin
      q.delete();
      for (int k = 0; k < 4; k++) ml[k] = '0;
      mnl = 0; hold = 0; maddr = 0; mwrc = 0; movf = 0;
    end else begin
      if (hold == 0) begin
        if (flush && mnl > 0) begin
          mgrp = {ml[3], ml[2], ml[1], ml[0]};
          for (int k = 0; k < 4; k++) ml[k] = '0;
          mnl  = 0;
          hold = BN_LAT + 3;
        end else if (q.size() > 0) begin
          ml[mnl] = q.pop_front();
          mnl++;
          if (mnl == 4) begin
            mgrp = {ml[3], ml[2], ml[1], ml[0]};
            for (int k = 0; k < 4; k++) ml[k] = '0;
            mnl  = 0;
            hold = BN_LAT + 3;
          end
        end
      end else begin
        if (hold <= 2) mwrc = (mwrc + 1) % AMOD;
        if (hold == 1) maddr = (maddr + 2) % AMOD;
        hold--;
      end
      if (bif.in_valid) begin
        if (q.size() < FIFO_DEPTH) q.push_back(bif.in_data);
        else movf = 1;
      end
    end
    r         = bn_f(mgrp);
    exp_we    = (hold == 1) || (hold == 2);
    exp_start = (hold == BN_LAT + 3);
    exp_input = mgrp;
    exp_waddr = ADDR_W'((hold == 2) ? maddr : (maddr + 1) % AMOD);
    exp_wdata = (hold == 2) ? r[31:0] : r[63:32];
    exp_busy  = (hold != 0) || (q.size() != 0);
    exp_ovf   = movf;
    exp_wrc   = ADDR_W'(mwrc);
  end

  // Per-cycle comparison and write logging.
  int          log_addr[$];
  logic [31:0] log_data[$];
  logic [63:0] last_in = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("sram_we", bif.sram_we, exp_we);
      if (exp_we) begin
        check("sram_waddr", bif.sram_waddr, exp_waddr);
        check("sram_wdata", bif.sram_wdata, exp_wdata);
      end
      check("bn_start", bif.bn_start, exp_start);
      if (exp_start) check("bn_input", bif.bn_input, exp_input);
      check("busy", busy, exp_busy);
      check("overflow", overflow, exp_ovf);
      check("wr_count", wr_count, exp_wrc);
      if (bif.sram_we) begin
        log_addr.push_back(int'(bif.sram_waddr));
        log_data.push_back(bif.sram_wdata);
      end
      if (bif.bn_start) last_in = bif.bn_input;
    end
  end

  task automatic cyc(input logic v, input logic [15:0] d, input logic f, input logic c);
    bif.in_valid = v;
    bif.in_data  = d;
    flush        = f;
    clear        = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    idle(2);
    while (busy && k < budget) begin
      idle(1);
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", budget);
    end
  endtask

  task automatic restart();
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    idle(1);
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bif.in_valid = 1'b0;
    bif.in_data  = '0;
    #2;
    check("rst_sram_we", bif.sram_we, 0);
    check("rst_sram_waddr", bif.sram_waddr, 0);
    check("rst_sram_wdata", bif.sram_wdata, 0);
    check("rst_bn_start", bif.bn_start, 0);
    check("rst_bn_input", bif.bn_input, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_wr_count", wr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // four samples, BN adds one per lane
    for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    wait_idle(60);
    check("t1_bn_input", last_in, 64'h0004_0003_0002_0001);
    check("t1_writes", log_data.size(), 2);
    if (log_data.size() >= 2) begin
      check("t1_addr0", log_addr[0], 0);
      check("t1_data0", log_data[0], 32'h0003_0002);
      check("t1_addr1", log_addr[1], 1);
      check("t1_data1", log_data[1], 32'h0005_0004);
    end
    check("t1_wr_count", wr_count, 2);

    // back-to-back groups: FIFO reaches full but never drops
    restart();
    for (int i = 0; i < 12; i++) cyc(1'b1, 16'(16'h10 + i), 1'b0, 1'b0);
    wait_idle(200);
    check("t2_writes", log_data.size(), 6);
    for (int i = 0; i < log_addr.size(); i++) check("t2_addr", log_addr[i], i);
    if (log_data.size() >= 1) check("t2_data0", log_data[0], 32'h0012_0011);
    check("t2_overflow", overflow, 0);

    // overflow: exactly the last of 13 samples is lost
    restart();
    for (int i = 0; i < 4 + FIFO_DEPTH + 1; i++) cyc(1'b1, 16'(100 + i), 1'b0, 1'b0);
    wait_idle(200);
    check("t3_overflow", overflow, 1);
    check("t3_writes", log_data.size(), 6);
    if (log_data.size() >= 6) check("t3_last", log_data[5], 32'h0070_006F);

    // flush of a partial group, then a flush with nothing pending
    restart();
    cyc(1'b1, 16'd7, 1'b0, 1'b0);
    cyc(1'b1, 16'd8, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 16'd0, 1'b1, 1'b0);
    wait_idle(60);
    check("t4_bn_input", last_in, 64'h0000_0000_0008_0007);
    check("t4_writes", log_data.size(), 2);
    if (log_data.size() >= 2) begin
      check("t4_data0", log_data[0], 32'h0009_0008);
      check("t4_data1", log_data[1], 32'h0001_0001);
    end
    cyc(1'b0, 16'd0, 1'b1, 1'b0);
    idle(3);
    check("t4_empty_flush_busy", busy, 0);
    check("t4_empty_flush_writes", log_data.size(), 2);

    // clear while waiting on the BN unit
    restart();
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h21 + i), 1'b0, 1'b0);
    idle(8);
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    idle(30);
    check("t5_no_write", log_data.size(), 0);
    check("t5_wr_count", wr_count, 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h31 + i), 1'b0, 1'b0);
    wait_idle(60);
    check("t5_writes", log_data.size(), 2);
    if (log_data.size() >= 1) begin
      check("t5_addr0", log_addr[0], 0);
      check("t5_data0", log_data[0], 32'h0033_0032);
    end

    // reset while in WR0
    restart();
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h41 + i), 1'b0, 1'b0);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bif.sram_we) found = 1;
    end
    if (!found) begin
      n_cmp++;
      n_fail++;
      $display("FAIL t6_wr0: sram_we never rose within 40 cycles, required 1");
    end
    rst_n = 1'b0;
    #1;
    check("t6_sram_we", bif.sram_we, 0);
    check("t6_sram_waddr", bif.sram_waddr, 0);
    check("t6_sram_wdata", bif.sram_wdata, 0);
    check("t6_bn_start", bif.bn_start, 0);
    check("t6_bn_input", bif.bn_input, 0);
    check("t6_busy", busy, 0);
    check("t6_wr_count", wr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    log_addr.delete();
    log_data.delete();
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h51 + i), 1'b0, 1'b0);
    wait_idle(60);
    check("t6_writes", log_data.size(), 2);
    if (log_addr.size() >= 1) check("t6_addr0", log_addr[0], 0);

    // randomised traffic at varying densities; address wraps many times
    restart();
    for (int b = 0; b < 6; b++) begin
      int pv;
      pv = (b % 3 == 0) ? 95 : ((b % 3 == 1) ? 50 : 20);
      for (int i = 0; i < 500; i++)
        cyc($urandom_range(0, 99) < pv, 16'($urandom), $urandom_range(0, 99) < 2,
            $urandom_range(0, 999) < 2);
    end
    wait_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
